// File: rtl/vec_mem_unit.sv
// Memory-side responder for the control/memory handshake: moves one vector or one
// scalar between the operand registers and a single-port synchronous data RAM.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for cl_mem_st; operands latched on accept
// S_ISSUE | one RAM access per cycle, lane idx at base+idx
// S_DRAIN | loads only: capture read data of the last issued lane
// S_DONE  | one-cycle mem_rdy pulse, then back to S_IDLE
module vec_mem_unit #(
   parameter int LANES = 8,
   parameter int DW    = 8,
   parameter int AW    = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cl_mem_st,
   input  logic [1:0]            cl_mem_op,
   input  logic [AW-1:0]         base_addr,
   input  logic [LANES*DW-1:0]   st_vec,
   input  logic [DW-1:0]         st_esc,
   output logic                  mem_rdy,
   output logic                  mem_busy,
   output logic [LANES*DW-1:0]   ld_vec,
   output logic [DW-1:0]         ld_esc,
   output logic [AW-1:0]         ram_addr,
   output logic                  ram_we,
   output logic [DW-1:0]         ram_wdata,
   input  logic [DW-1:0]         ram_rdata
);

   localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [1:0]            op_q;
   logic [AW-1:0]         addr_q;
   logic [LANES*DW-1:0]   vec_q;
   logic [DW-1:0]         esc_q;
   logic [IW-1:0]         idx_q;
   logic                  rd_vld_q, rd_esc_q;
   logic [IW-1:0]         rd_idx_q;
   logic                  accept, issue_last, is_load, is_esc;

   // op[1] selects load vs store, op[0] selects scalar vs vector
   assign is_load    = op_q[1];
   assign is_esc     = op_q[0];
   assign issue_last = is_esc ? 1'b1 : (idx_q == IW'(LANES - 1));
   assign ram_addr   = addr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      mem_rdy   = 1'b0;
      mem_busy  = 1'b1;
      ram_we    = 1'b0;
      ram_wdata = '0;
      case (state_q)
         S_IDLE: begin
            mem_busy = 1'b0;
            if (cl_mem_st) begin
               accept  = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!is_load) begin
               ram_we    = 1'b1;
               ram_wdata = is_esc ? esc_q : vec_q[idx_q*DW +: DW];
            end
            if (issue_last) state_d = is_load ? S_DRAIN : S_DONE;
         end
         S_DRAIN: state_d = S_DONE;
         S_DONE: begin
            mem_rdy = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Address register holds on the last issue cycle so DRAIN keeps the final address
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= '0;
         addr_q   <= '0;
         vec_q    <= '0;
         esc_q    <= '0;
         idx_q    <= '0;
         rd_vld_q <= 1'b0;
         rd_esc_q <= 1'b0;
         rd_idx_q <= '0;
         ld_vec   <= '0;
         ld_esc   <= '0;
      end else begin
         rd_vld_q <= 1'b0;
         if (accept) begin
            op_q   <= cl_mem_op;
            addr_q <= base_addr;
            vec_q  <= st_vec;
            esc_q  <= st_esc;
            idx_q  <= '0;
         end
         if (state_q == S_ISSUE) begin
            rd_vld_q <= is_load;
            rd_esc_q <= is_esc;
            rd_idx_q <= idx_q;
            if (!issue_last) begin
               idx_q  <= idx_q + IW'(1);
               addr_q <= addr_q + AW'(1);
            end
         end
         if (rd_vld_q) begin
            if (rd_esc_q) ld_esc <= ram_rdata;
            else          ld_vec[rd_idx_q*DW +: DW] <= ram_rdata;
         end
      end
   end

endmodule

// File: tb/tb_vec_mem_unit.sv
// Bench for vec_mem_unit: 1-cycle-read RAM model plus an array-based reference of
// RAM contents and load results, driven by directed and randomized operations.
module tb_vec_mem_unit;
   localparam int LANES = 8;
   localparam int DW    = 8;
   localparam int AW    = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cl_mem_st;
   logic [1:0]    cl_mem_op;
   logic [7:0]    base_addr;
   logic [63:0]   st_vec;
   logic [7:0]    st_esc;
   logic          mem_rdy, mem_busy;
   logic [63:0]   ld_vec;
   logic [7:0]    ld_esc;
   logic [7:0]    ram_addr;
   logic          ram_we;
   logic [7:0]    ram_wdata;
   logic [7:0]    ram_rdata;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vec_mem_unit #(.LANES(LANES), .DW(DW), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .cl_mem_st(cl_mem_st), .cl_mem_op(cl_mem_op),
      .base_addr(base_addr), .st_vec(st_vec), .st_esc(st_esc),
      .mem_rdy(mem_rdy), .mem_busy(mem_busy), .ld_vec(ld_vec), .ld_esc(ld_esc),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   logic [7:0] ram [256];
   always @(posedge clk) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      ram_rdata <= ram[ram_addr];
   end

   // reference model state
   logic [7:0]  ref_mem [256];
   logic [63:0] ref_ld_vec;
   logic [7:0]  ref_ld_esc;

   // observations of the last run_op
   int          obs_lat, obs_rdy_cnt;
   logic [7:0]  obs_addr[$];
   logic [7:0]  obs_data[$];
   logic [63:0] obs_ld_vec;
   logic [7:0]  obs_ld_esc;

   function automatic int ref_latency(input logic [1:0] op);
      case (op)
         2'b00:   return LANES + 1;
         2'b01:   return 2;
         2'b10:   return LANES + 2;
         default: return 3;
      endcase
   endfunction

   task automatic ref_apply(input logic [1:0] op, input logic [7:0] base,
                            input logic [63:0] vec, input logic [7:0] esc);
      int n = op[0] ? 1 : LANES;
      for (int i = 0; i < n; i++) begin
         logic [7:0] a = base + 8'(i);
         if (!op[1])     ref_mem[a] = op[0] ? esc : vec[i*8 +: 8];
         else if (op[0]) ref_ld_esc = ref_mem[a];
         else            ref_ld_vec[i*8 +: 8] = ref_mem[a];
      end
   endtask

   task automatic run_op(input logic [1:0] op, input logic [7:0] base,
                         input logic [63:0] vec, input logic [7:0] esc, input bit scramble);
      obs_addr.delete();
      obs_data.delete();
      obs_lat = -1;
      obs_rdy_cnt = 0;
      @(negedge clk);
      cl_mem_st = 1'b1;
      cl_mem_op = op;
      base_addr = base;
      st_vec    = vec;
      st_esc    = esc;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         cl_mem_st = 1'b0;
         if (ram_we) begin
            obs_addr.push_back(ram_addr);
            obs_data.push_back(ram_wdata);
         end
         if (mem_rdy) begin
            obs_rdy_cnt++;
            if (obs_lat < 0) begin
               obs_lat = c;
               obs_ld_vec = ld_vec;
               obs_ld_esc = ld_esc;
            end
         end
         if (scramble) begin
            base_addr = 8'($urandom);
            st_vec    = {$urandom, $urandom};
            st_esc    = 8'($urandom);
            cl_mem_op = 2'($urandom);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cl_mem_st = 1'b0; cl_mem_op = '0; base_addr = '0; st_vec = '0; st_esc = '0;
      repeat (2) @(negedge clk);
      checks++; if (mem_rdy !== 1'b0)    begin failures++; $display("FAIL reset_mem_rdy: got %0h expected 0", mem_rdy); end
      checks++; if (mem_busy !== 1'b0)   begin failures++; $display("FAIL reset_mem_busy: got %0h expected 0", mem_busy); end
      checks++; if (ld_vec !== 64'h0)    begin failures++; $display("FAIL reset_ld_vec: got %0h expected 0", ld_vec); end
      checks++; if (ld_esc !== 8'h0)     begin failures++; $display("FAIL reset_ld_esc: got %0h expected 0", ld_esc); end
      checks++; if (ram_addr !== 8'h0)   begin failures++; $display("FAIL reset_ram_addr: got %0h expected 0", ram_addr); end
      checks++; if (ram_we !== 1'b0)     begin failures++; $display("FAIL reset_ram_we: got %0h expected 0", ram_we); end
      checks++; if (ram_wdata !== 8'h0)  begin failures++; $display("FAIL reset_ram_wdata: got %0h expected 0", ram_wdata); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [1:0]  d_op [4];
      logic [7:0]  d_base [4];
      int          d_lat [4];
      logic [63:0] vec = 64'h1716151413121110;
      d_op[0] = 2'b10; d_base[0] = 8'hFC; d_lat[0] = 10;
      d_op[1] = 2'b00; d_base[1] = 8'hF8; d_lat[1] = 9;
      d_op[2] = 2'b01; d_base[2] = 8'h40; d_lat[2] = 2;
      d_op[3] = 2'b11; d_base[3] = 8'h40; d_lat[3] = 3;
      for (int k = 0; k < 4; k++) begin
         int n_exp = d_op[k][1] ? 0 : (d_op[k][0] ? 1 : LANES);
         run_op(d_op[k], d_base[k], vec, 8'h3C, 1'b0);
         ref_apply(d_op[k], d_base[k], vec, 8'h3C);
         checks++; if (obs_lat != d_lat[k]) begin failures++; $display("FAIL dir%0d_latency: got %0d expected %0d", k, obs_lat, d_lat[k]); end
         checks++; if (obs_rdy_cnt != 1) begin failures++; $display("FAIL dir%0d_rdy_count: got %0d expected 1", k, obs_rdy_cnt); end
         checks++; if (obs_addr.size() != n_exp) begin failures++; $display("FAIL dir%0d_write_count: got %0d expected %0d", k, obs_addr.size(), n_exp); end
         for (int i = 0; i < obs_addr.size() && i < n_exp; i++) begin
            logic [7:0] ea = d_base[k] + 8'(i);
            logic [7:0] ed = d_op[k][0] ? 8'h3C : vec[i*8 +: 8];
            checks++; if (obs_addr[i] !== ea || obs_data[i] !== ed) begin failures++;
               $display("FAIL dir%0d_write%0d: got %0h/%0h expected %0h/%0h", k, i, obs_addr[i], obs_data[i], ea, ed); end
         end
         if (d_op[k][1]) begin
            checks++; if (obs_ld_vec !== ref_ld_vec) begin failures++; $display("FAIL dir%0d_ld_vec: got %0h expected %0h", k, obs_ld_vec, ref_ld_vec); end
            checks++; if (obs_ld_esc !== ref_ld_esc) begin failures++; $display("FAIL dir%0d_ld_esc: got %0h expected %0h", k, obs_ld_esc, ref_ld_esc); end
         end
      end
      checks++; if (ld_vec !== 64'hA6A7A4A55A5B5859) begin failures++; $display("FAIL wrap_load_ld_vec: got %0h expected a6a7a4a55a5b5859", ld_vec); end
      checks++; if (ld_esc !== 8'h3C) begin failures++; $display("FAIL esc_roundtrip: got %0h expected 3c", ld_esc); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (ram[8'hF8 + i] !== 8'(8'h10 + i)) begin failures++;
            $display("FAIL gv_ram_%0d: got %0h expected %0h", i, ram[8'hF8 + i], 8'(8'h10 + i)); end
      end
   endtask

   task automatic test_back_to_back();
      int starts = 0, rdy = 0, gap = 0, bad_gap = 0;
      bit prev_busy = 1'b0;
      @(negedge clk);
      cl_mem_op = 2'b01; base_addr = 8'h60; st_esc = 8'h5A; cl_mem_st = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (mem_busy && !prev_busy) begin
            starts++;
            if (starts > 1 && gap != 1) bad_gap++;
            ref_apply(2'b01, base_addr, 64'h0, 8'h5A);
            base_addr = base_addr + 8'd1;
            if (starts == 3) cl_mem_st = 1'b0;
         end
         if (mem_busy) gap = 0;
         else          gap++;
         if (mem_rdy) rdy++;
         prev_busy = mem_busy;
      end
      cl_mem_st = 1'b0;
      checks++; if (rdy != 3)     begin failures++; $display("FAIL b2b_rdy_pulses: got %0d expected 3", rdy); end
      checks++; if (starts != 3)  begin failures++; $display("FAIL b2b_ops: got %0d expected 3", starts); end
      checks++; if (bad_gap != 0) begin failures++; $display("FAIL b2b_idle_gap: got %0d bad gaps expected 0", bad_gap); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (ram[8'h60 + i] !== ref_mem[8'h60 + i]) begin failures++;
            $display("FAIL b2b_ram_%0d: got %0h expected %0h", i, ram[8'h60 + i], ref_mem[8'h60 + i]); end
      end
   endtask

   task automatic test_reset_mid();
      logic [63:0] vec = {$urandom, $urandom};
      int rdy = 0, busy = 0;
      @(negedge clk);
      cl_mem_st = 1'b1; cl_mem_op = 2'b00; base_addr = 8'h80; st_vec = vec;
      repeat (3) begin
         @(negedge clk);
         cl_mem_st = 1'b0;
      end
      checks++; if (ram_we !== 1'b1) begin failures++; $display("FAIL mid_we_before: got %0h expected 1", ram_we); end
      rst_n = 1'b0;
      #1;
      checks++; if (ram_we !== 1'b0)   begin failures++; $display("FAIL mid_we_async: got %0h expected 0", ram_we); end
      checks++; if (mem_busy !== 1'b0) begin failures++; $display("FAIL mid_busy_async: got %0h expected 0", mem_busy); end
      ref_mem[8'h80] = vec[7:0];
      ref_mem[8'h81] = vec[15:8];
      ref_ld_vec = '0;
      ref_ld_esc = '0;
      repeat (2) begin
         @(negedge clk);
         if (mem_rdy) rdy++;
      end
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (mem_rdy) rdy++;
         if (mem_busy) busy++;
      end
      checks++; if (rdy != 0)  begin failures++; $display("FAIL mid_no_rdy: got %0d expected 0", rdy); end
      checks++; if (busy != 0) begin failures++; $display("FAIL mid_idle_after: got %0d busy cycles expected 0", busy); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (ram[8'h80 + i] !== ref_mem[8'h80 + i]) begin failures++;
            $display("FAIL mid_ram_%0d: got %0h expected %0h", i, ram[8'h80 + i], ref_mem[8'h80 + i]); end
      end
      checks++; if (ld_vec !== ref_ld_vec) begin failures++; $display("FAIL mid_ld_vec: got %0h expected %0h", ld_vec, ref_ld_vec); end
      run_op(2'b01, 8'h83, 64'h0, 8'hE7, 1'b0);
      ref_apply(2'b01, 8'h83, 64'h0, 8'hE7);
      checks++; if (obs_lat != 2) begin failures++; $display("FAIL mid_next_latency: got %0d expected 2", obs_lat); end
      checks++; if (ram[8'h83] !== 8'hE7) begin failures++; $display("FAIL mid_next_write: got %0h expected e7", ram[8'h83]); end
   endtask

   task automatic test_random();
      int mism = 0;
      for (int k = 0; k < 30; k++) begin
         logic [1:0]  op   = 2'($urandom_range(0, 3));
         logic [7:0]  base = 8'($urandom);
         logic [63:0] vec  = {$urandom, $urandom};
         logic [7:0]  esc  = 8'($urandom);
         bit          scr  = (k < 4) ? 1'b1 : 1'($urandom);
         int          n_exp = op[1] ? 0 : (op[0] ? 1 : LANES);
         int          lat_exp = ref_latency(op);
         if (k < 4) op = 2'b00;
         n_exp = op[1] ? 0 : (op[0] ? 1 : LANES);
         lat_exp = ref_latency(op);
         run_op(op, base, vec, esc, scr);
         ref_apply(op, base, vec, esc);
         checks++; if (obs_lat != lat_exp) begin failures++; $display("FAIL rnd%0d_latency op=%0d: got %0d expected %0d", k, op, obs_lat, lat_exp); end
         checks++; if (obs_rdy_cnt != 1) begin failures++; $display("FAIL rnd%0d_rdy_count: got %0d expected 1", k, obs_rdy_cnt); end
         checks++; if (obs_addr.size() != n_exp) begin failures++; $display("FAIL rnd%0d_write_count: got %0d expected %0d", k, obs_addr.size(), n_exp); end
         for (int i = 0; i < obs_addr.size() && i < n_exp; i++) begin
            logic [7:0] ea = base + 8'(i);
            logic [7:0] ed = op[0] ? esc : vec[i*8 +: 8];
            checks++; if (obs_addr[i] !== ea || obs_data[i] !== ed) begin failures++;
               $display("FAIL rnd%0d_write%0d: got %0h/%0h expected %0h/%0h", k, i, obs_addr[i], obs_data[i], ea, ed); end
         end
         checks++; if (obs_ld_vec !== ref_ld_vec || obs_ld_esc !== ref_ld_esc) begin failures++;
            $display("FAIL rnd%0d_load: got %0h/%0h expected %0h/%0h", k, obs_ld_vec, obs_ld_esc, ref_ld_vec, ref_ld_esc); end
      end
      for (int a = 0; a < 256; a++) if (ram[a] !== ref_mem[a]) mism++;
      checks++; if (mism != 0) begin failures++; $display("FAIL rnd_ram_image: got %0d differing words expected 0", mism); end
   endtask

   initial begin
      for (int a = 0; a < 256; a++) begin
         ram[a]     = 8'(a) ^ 8'hA5;
         ref_mem[a] = 8'(a) ^ 8'hA5;
      end
      ref_ld_vec = '0;
      ref_ld_esc = '0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
